// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add multiplier for MUL in the EX stage.
//
// Stalls the pipeline while a MUL runs, walks the multiplier one bit per cycle
// and returns the low XLEN bits of rs1_i * rs2_i. The result is the same for
// signed and unsigned operands.
//
// Optional build macro:
//   MUL_SEQUENCER_EARLY_EXIT_EN - finish as soon as no multiplier bits remain.
//                                 At least one RUN cycle always executes.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous reset, active low
//   start_i  - EX-stage instruction is MUL (held while stall_o is high)
//   flush_i  - EX-stage flush; aborts any operation, beats start_i
//   rs1_i    - multiplicand
//   rs2_i    - multiplier
//   stall_o  - freeze PC/IF/ID/ID-EX
//   done_o   - one-cycle pulse, result_o valid
//   result_o - low XLEN bits of the product, held until the next completion
module mul_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplr_q, mplr_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_sum;
    logic              last_iter;

    // Partial-product accumulate; carry out of the top bit is dropped.
    assign acc_sum = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
    // Stop once the shifted-out multiplier would be all zero.
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1)) || (mplr_q[XLEN-1:1] == '0);
`else
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (!flush_i && start_i) begin
                    mcand_d = rs1_i;
                    mplr_d  = rs2_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d   = acc_sum;
                    mcand_d = mcand_q << 1;
                    mplr_d  = mplr_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        result_d = acc_sum;
                        state_d  = StDone;
                    end
                end
            end
            // start_i here still belongs to the finishing instruction.
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Gated by rst_i so the pipeline is never frozen while in reset.
    assign stall_o  = rst_i && !flush_i &&
                      (((state_q == StIdle) && start_i) || (state_q == StRun));
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic            flush;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    int checks;
    int failures;

    mul_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .flush_i (flush),
        .rs1_i   (rs1),
        .rs2_i   (rs2),
        .stall_o (stall),
        .done_o  (done),
        .result_o(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: number of RUN cycles for a given multiplier.
    function automatic int exp_runs(input logic [XLEN-1:0] b);
`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
        int r;
        r = 1;
        for (int i = 0; i < XLEN; i++) if (b[i]) r = i + 1;
        return r;
`else
        return XLEN;
`endif
    endfunction

    // Drive one MUL starting at cycle 0 (inputs applied #1 after posedge),
    // record stall/done per cycle sampled at negedge. Operands are scrambled
    // after cycle 0; start drops the cycle after done or flush.
    task automatic do_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input int flush_at, input int ncyc,
                          output logic [127:0] st, output logic [127:0] dn);
        bit active;
        active = 1'b1;
        st = '0;
        dn = '0;
        for (int c = 0; c < ncyc; c++) begin
            start = active;
            flush = (c == flush_at);
            if (c == 0) begin
                rs1 = a;
                rs2 = b;
            end else begin
                rs1 = $urandom;
                rs2 = $urandom;
            end
            @(negedge clk);
            st[c] = stall;
            dn[c] = done;
            if (done || c == flush_at) active = 1'b0;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
        logic [127:0] st, dn, es, ed;
        logic [XLEN-1:0] prod;
        int runs, ncyc;
        prod = a * b;
        runs = exp_runs(b);
        ncyc = runs + 5;
        es = '0;
        ed = '0;
        for (int c = 0; c < ncyc; c++) begin
            es[c] = (c <= runs);
            ed[c] = (c == runs + 1);
        end
        do_mul(a, b, -1, ncyc, st, dn);
        checks++;
        if (st !== es) begin
            failures++;
            $display("FAIL %s stall pattern got=%h exp=%h", name, st, es);
        end
        checks++;
        if (dn !== ed) begin
            failures++;
            $display("FAIL %s done pattern got=%h exp=%h", name, dn, ed);
        end
        checks++;
        if (result !== prod) begin
            failures++;
            $display("FAIL %s result got=%h exp=%h", name, result, prod);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #2;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%b exp=0", stall);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        checks++;
        if (result !== '0) begin
            failures++;
            $display("FAIL reset_result got=%h exp=0", result);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        run_and_check("mul_3x5", 32'd3, 32'd5);
        run_and_check("wrap_ffffffff_x2", 32'hFFFF_FFFF, 32'd2);
        run_and_check("msb_x_msb", 32'h8000_0000, 32'h8000_0000);
        run_and_check("x_zero", 32'd5, 32'd0);
        run_and_check("x_one", 32'd7, 32'd1);
    endtask

    task automatic test_random();
        logic [XLEN-1:0] a, b;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 2 == 1) b = b >> $urandom_range(0, 31);
            run_and_check($sformatf("random_%0d", i), a, b);
        end
    endtask

    task automatic test_flush();
        logic [127:0] st, dn, es;
        int runs, f;
        run_and_check("pre_flush_2x21", 32'd2, 32'd21);
        runs = exp_runs(32'd9);
        f = (runs >= 10) ? 10 : runs;
        es = '0;
        for (int c = 0; c < f; c++) es[c] = 1'b1;
        do_mul(32'd7, 32'd9, f, f + 4, st, dn);
        checks++;
        if (st !== es) begin
            failures++;
            $display("FAIL flush_stall got=%h exp=%h", st, es);
        end
        checks++;
        if (dn !== '0) begin
            failures++;
            $display("FAIL flush_no_done got=%h exp=0", dn);
        end
        checks++;
        if (result !== 32'd42) begin
            failures++;
            $display("FAIL flush_result_kept got=%h exp=%h", result, 32'd42);
        end
        // flush together with start in IDLE: nothing starts
        do_mul(32'd11, 32'd13, 0, 6, st, dn);
        checks++;
        if (st !== '0 || dn !== '0) begin
            failures++;
            $display("FAIL idle_flush got stall=%h done=%h exp=0", st, dn);
        end
        run_and_check("post_flush_7x9", 32'd7, 32'd9);
    endtask

    task automatic test_back_to_back();
        logic [127:0] st, dn, es, ed;
        logic [XLEN-1:0] mid_result;
        int d1, d2;
        d1 = exp_runs(32'd5) + 1;
        d2 = d1 + 1 + exp_runs(32'd6) + 1;
        es = '0;
        ed = '0;
        st = '0;
        dn = '0;
        mid_result = '0;
        for (int c = 0; c <= d2 + 3; c++) begin
            es[c] = (c < d1) || (c > d1 && c < d2);
            ed[c] = (c == d1) || (c == d2);
        end
        for (int c = 0; c <= d2 + 3; c++) begin
            start = (c <= d2);
            flush = 1'b0;
            if (c == 0) begin
                rs1 = 32'd3;
                rs2 = 32'd5;
            end else if (c == d1 + 1) begin
                rs1 = 32'd4;
                rs2 = 32'd6;
            end else begin
                rs1 = $urandom;
                rs2 = $urandom;
            end
            @(negedge clk);
            st[c] = stall;
            dn[c] = done;
            if (c == d1) mid_result = result;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++;
        if (dn !== ed) begin
            failures++;
            $display("FAIL b2b_done got=%h exp=%h", dn, ed);
        end
        checks++;
        if (st !== es) begin
            failures++;
            $display("FAIL b2b_stall got=%h exp=%h", st, es);
        end
        checks++;
        if (mid_result !== 32'd15) begin
            failures++;
            $display("FAIL b2b_first_result got=%h exp=%h", mid_result, 32'd15);
        end
        checks++;
        if (result !== 32'd24) begin
            failures++;
            $display("FAIL b2b_second_result got=%h exp=%h", result, 32'd24);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] st, dn;
        run_and_check("pre_reset_3x5", 32'd3, 32'd5);
        start = 1'b1;
        rs1 = 32'h0000_1234;
        rs2 = 32'hF000_5678;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            rs1 = $urandom;
            rs2 = $urandom;
        end
        start = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_ctrl got stall=%b done=%b exp=0/0", stall, done);
        end
        checks++;
        if (result !== '0) begin
            failures++;
            $display("FAIL reset_mid_result got=%h exp=0", result);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Idle after release: no stall, no stray done.
        do_mul(32'd0, 32'd0, 0, 5, st, dn);
        checks++;
        if (st !== '0 || dn !== '0) begin
            failures++;
            $display("FAIL reset_mid_idle got stall=%h done=%h exp=0", st, dn);
        end
        run_and_check("post_reset_6x7", 32'd6, 32'd7);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        flush    = 1'b0;
        rs1      = '0;
        rs2      = '0;
        rst      = 1'b1;
        test_reset();
        test_basic();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle shift-add sequencer for the MUL operation in the EX stage.
- Replaces the single-cycle multiply path: while a MUL is active, it stalls the pipeline, iterates over the operands and returns the low XLEN bits of the product.
- Sits beside the ALU. Upstream EX decode asserts start_i when the ALU control selects MUL; the hazard/stall logic consumes stall_o.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- start_i  input  1  EX-stage instruction is MUL; held stable while stall_o is high.
- flush_i  input  1  EX-stage flush (branch taken); aborts the operation.
- rs1_i  input  XLEN  multiplicand.
- rs2_i  input  XLEN  multiplier.
- stall_o  output  1  freeze PC/IF/ID/ID-EX registers.
- done_o  output  1  one-cycle pulse: result_o valid, pipeline may advance.
- result_o  output  XLEN  low XLEN bits of rs1_i*rs2_i.

Behaviour:
- Reset: asynchronous on rst_i low.
  - State -> IDLE; acc, mcand, mplr, cnt -> 0.
  - result_o = 0, done_o = 0, stall_o = 0.
  - Reset mid-operation discards all progress.
- States: IDLE, RUN, DONE. State is registered.
- IDLE:
  - If flush_i: stay in IDLE.
  - Else if start_i: latch mcand = rs1_i, mplr = rs2_i, acc = 0, cnt = 0; go to RUN.
- RUN, each cycle:
  - If mplr[0], acc <= acc + mcand, modulo 2^XLEN, carry discarded.
  - mcand <= mcand << 1; mplr <= mplr >> 1; cnt <= cnt + 1.
  - When cnt == XLEN-1: write result_o <= final acc and go to DONE.
- DONE:
  - done_o = 1 (registered, equals state==DONE); stall_o = 0.
  - Next state is IDLE unconditionally.
  - start_i is ignored in DONE: it belongs to the same instruction, since ID/EX updates at the end of this cycle.
- stall_o is combinational: (state==IDLE && start_i && !flush_i) || state==RUN.
- Latency (no early exit): start sampled in cycle 0; RUN covers cycles 1..XLEN; done_o in cycle XLEN+1; stall_o high in cycles 0..XLEN.
- flush_i:
  - Highest priority in every state; takes precedence over start_i.
  - Next state IDLE; no done_o; result_o unchanged.
  - stall_o drops in the same cycle that flush_i is seen in RUN.
- Signedness: low-XLEN product is identical for signed and unsigned operands; no sign handling.
- Operand changes on rs1_i/rs2_i after latching have no effect.
- result_o holds its last value until the next completion.
- Back-to-back MULs: the second start_i is seen in the IDLE cycle after DONE. Minimum spacing is XLEN+2 cycles.

Optional Feature:
- Macro: MUL_SEQUENCER_EARLY_EXIT_EN.
- Defined: in RUN, go to DONE when cnt == XLEN-1 OR the next mplr (mplr >> 1) == 0. At least one RUN cycle always executes. Product value is unchanged; only latency shrinks, to (index of the highest set bit of rs2_i) + 1 RUN cycles.
- Undefined: fixed XLEN RUN cycles; the compare logic is absent.

Test Plan:
- rs1=3, rs2=5, start in cycle 0 -> stall_o high cycles 0..32; done_o=1 only in cycle 33; result_o=15.
- rs1=0xFFFFFFFF, rs2=2 -> result_o=0xFFFFFFFE (wrap). rs1=0x80000000, rs2=0x80000000 -> result_o=0x00000000.
- Start 7*9; flush_i=1 in cycle 10 -> stall_o=0 in cycle 10; no done_o; result_o keeps prior value; next start runs a full XLEN cycles.
- Start held high through DONE, new operands 4*6 presented after done -> exactly one done per instruction; second done_o in cycle 67; result_o=24.
- rst_i low in cycle 15 of an operation -> stall_o=0, done_o=0, result_o=0 immediately; resumes from IDLE after release.
- With MUL_SEQUENCER_EARLY_EXIT_EN: 7*1 -> done_o in cycle 2, result_o=7. 5*0 -> one RUN cycle, done_o in cycle 2, result_o=0.
